// File: rtl/deserializer_fifo_top.sv
// Serial-to-parallel receiver feeding a DEPTH-entry byte queue, single 1 MHz domain.
// Build option: DESER_LSB_FIRST_EN selects LSB-first bit assembly (default MSB-first).
module deserializer_fifo_top #(
  parameter int unsigned FAST_DIV = 10,
  parameter int unsigned SLOW_DIV = 100,
  parameter int unsigned DEPTH    = 8
) (
  input  logic       clock_1M,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       deq_in,
  output logic [7:0] data_out,
  output logic [3:0] len_out,
  output logic       status_out
);

  localparam int unsigned FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam int unsigned SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  logic [FW-1:0] fast_cnt_q, fast_cnt_d;
  logic [SW-1:0] slow_cnt_q, slow_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic          pending_q, pending_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          status_q, status_d;

  logic fast_tick, slow_tick, full, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fast_tick = (fast_cnt_q == FW'(FAST_DIV - 1));
  assign slow_tick = (slow_cnt_q == SW'(SLOW_DIV - 1));
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = slow_tick && deq_in && (count_q != '0);
  assign push      = slow_tick && pending_q && (!full || pop);

  // Next-state: tick dividers, bit assembly, queue push/pop and registered outputs
  always_comb begin
    fast_cnt_d  = fast_tick ? '0 : fast_cnt_q + FW'(1);
    slow_cnt_d  = slow_tick ? '0 : slow_cnt_q + SW'(1);
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    pend_byte_d = pend_byte_q;
    pending_d   = pending_q;
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_d      = head_q;
    status_d    = status_q;

    // A pending byte blocks capture, so stalled bits are dropped outright
    if (fast_tick && write_in && !pending_q) begin
`ifdef DESER_LSB_FIRST_EN
      shreg_d = {data_in, shreg_q[7:1]};
`else
      shreg_d = {shreg_q[6:0], data_in};
`endif
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        pend_byte_d = shreg_d;
        pending_d   = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = pend_byte_q;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      pending_d       = 1'b0;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    head_d   = (count_d == '0) ? 8'h00 : mem_d[rd_ptr_d];
    status_d = pending_d && (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clock_1M) begin
    if (reset) begin
      fast_cnt_q  <= '0;
      slow_cnt_q  <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      pend_byte_q <= '0;
      pending_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      status_q    <= 1'b0;
    end else begin
      fast_cnt_q  <= fast_cnt_d;
      slow_cnt_q  <= slow_cnt_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_byte_q <= pend_byte_d;
      pending_q   <= pending_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      status_q    <= status_d;
    end
  end

  assign data_out   = head_q;
  assign len_out    = count_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_deserializer_fifo_top.sv
// Directed self-checking bench for deserializer_fifo_top (default MSB-first build).
module tb_deserializer_fifo_top;

  logic       clock_1M = 1'b0;
  logic       reset    = 1'b1;
  logic       data_in  = 1'b0;
  logic       write_in = 1'b0;
  logic       deq_in   = 1'b0;
  logic [7:0] data_out;
  logic [3:0] len_out;
  logic       status_out;

  int tests = 0;
  int fails = 0;

  deserializer_fifo_top dut (
    .clock_1M  (clock_1M),
    .reset     (reset),
    .data_in   (data_in),
    .write_in  (write_in),
    .deq_in    (deq_in),
    .data_out  (data_out),
    .len_out   (len_out),
    .status_out(status_out)
  );

  always #5 clock_1M = ~clock_1M;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic [3:0] l,
                           input logic s);
    check({tag, "_data"}, data_out, d);
    check({tag, "_len"}, {4'h0, len_out}, {4'h0, l});
    check({tag, "_status"}, {7'h0, status_out}, {7'h0, s});
  endtask

  // Inputs change 1 time unit after a rising edge
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock_1M);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    wait_cyc(10);
    write_in = 1'b0;
    wait_cyc(140);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic deq_one();
    deq_in = 1'b1;
    wait_cyc(100);
    deq_in = 1'b0;
    wait_cyc(3);
  endtask

  logic [7:0] fill_v [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hAB, 8'hAC};
  logic [7:0] bv;

  initial begin
    // Reset
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    check_out("reset", 8'h00, 4'd0, 1'b0);

    // Single bytes 0x11..0x88, each enqueued then dequeued
    for (int k = 1; k <= 8; k++) begin
      bv = {4'(k), 4'(k)};
      send_byte(bv);
      check_out($sformatf("single_%0d", k), bv, 4'd1, 1'b0);
      deq_one();
      check_out($sformatf("single_deq_%0d", k), 8'h00, 4'd0, 1'b0);
    end

    // Fill to capacity, then drain in order
    for (int k = 0; k < 8; k++) send_byte(fill_v[k]);
    check_out("fill", 8'hAA, 4'd8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_head_%0d", k), data_out, fill_v[k]);
      deq_one();
      check($sformatf("drain_len_%0d", k), {4'h0, len_out}, 8'(7 - k));
    end
    check("drain_empty_data", data_out, 8'h00);

    // Overflow: ninth byte stalls against a full queue
    for (int k = 1; k <= 8; k++) send_byte({4'(k), 4'hA});
    check_out("ovf_full", 8'h1A, 4'd8, 1'b0);
    send_byte(8'h9A);
    check_out("ovf_stall", 8'h1A, 4'd8, 1'b1);

    // Bits sent during the stall must be dropped
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check_out("stall_drop", 8'h1A, 4'd8, 1'b1);

    // One dequeue admits the pending byte on the same tick
    deq_one();
    check_out("ovf_deq", 8'h2A, 4'd8, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("ovf_drain_%0d", k), data_out, {4'(k), 4'hA});
      deq_one();
    end
    check_out("ovf_empty", 8'h00, 4'd0, 1'b0);

    // Fresh byte after the stall proves no leftover bits were assembled
    send_byte(8'h5C);
    check_out("post_stall", 8'h5C, 4'd1, 1'b0);

    // Reset mid-byte with a queued byte present
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    check_out("mid_reset", 8'h00, 4'd0, 1'b0);
    send_byte(8'hC3);
    check_out("after_reset", 8'hC3, 4'd1, 1'b0);
    deq_one();
    check_out("after_reset_deq", 8'h00, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
